// File: rtl/alu_result_unit.sv
// Registered result-select stage with a sequential unsigned shift-add multiplier
// that owns the HI/LO register pair.
module alu_result_unit #(
   parameter int         WIDTH   = 32,
   parameter logic [5:0] F_ALU   = 6'd63,
   parameter logic [5:0] F_SHIFT = 6'd62,
   parameter logic [5:0] F_HI    = 6'd61,
   parameter logic [5:0] F_LO    = 6'd60,
   parameter logic [5:0] F_MULTU = 6'd25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       signal,
   input  logic             valid_in,
   output logic             ready,
   input  logic [WIDTH-1:0] alu_in,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [WIDTH-1:0] mul_a,
   input  logic [WIDTH-1:0] mul_b,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic             mul_done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             mul_done_q, mul_done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   step_sum;

   // Handshake: an operation transfers on a rising edge where valid_in && ready;
   // ready depends only on state, so the issuer simply holds the operation until then.
   assign busy      = (state_q == S_MUL);
   assign ready     = !busy;
   assign state_dbg = state_q;

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign mul_done     = mul_done_q;
   assign hi_out       = hi_q;
   assign lo_out       = lo_q;

   // One shift-add step: the carry-out lands in the top of acc, the sum LSB in mplier.
   assign step_sum = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

   always_comb begin
      state_d        = state_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      mul_done_d     = 1'b0;
      hi_d           = hi_q;
      lo_d           = lo_q;
      acc_d          = acc_q;
      mplier_d       = mplier_q;
      mcand_d        = mcand_q;
      count_d        = count_q;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               if (signal == F_MULTU) begin
                  acc_d    = '0;
                  mplier_d = mul_b;
                  mcand_d  = mul_a;
                  count_d  = CW'(WIDTH);
                  state_d  = S_MUL;
               end else begin
                  result_valid_d = 1'b1;
                  if (signal == F_ALU)        result_d = alu_in;
                  else if (signal == F_SHIFT) result_d = shift_in;
                  else if (signal == F_HI)    result_d = hi_q;
                  else if (signal == F_LO)    result_d = lo_q;
                  else                        result_d = '0;
               end
            end
         end
         S_MUL: begin
            acc_d    = step_sum[WIDTH:1];
            mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               hi_d       = step_sum[WIDTH:1];
               lo_d       = {step_sum[0], mplier_q[WIDTH-1:1]};
               mul_done_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         mul_done_q     <= 1'b0;
         hi_q           <= '0;
         lo_q           <= '0;
         acc_q          <= '0;
         mplier_q       <= '0;
         mcand_q        <= '0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         mul_done_q     <= mul_done_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         acc_q          <= acc_d;
         mplier_q       <= mplier_d;
         mcand_q        <= mcand_d;
         count_q        <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_result_unit.sv
// Directed and randomized bench for alu_result_unit: a WIDTH=32 instance checked
// against an arithmetic reference model, plus a WIDTH=8 multiply regression.
module tb_alu_result_unit;

   localparam logic [5:0] F_ALU   = 6'd63;
   localparam logic [5:0] F_SHIFT = 6'd62;
   localparam logic [5:0] F_HI    = 6'd61;
   localparam logic [5:0] F_LO    = 6'd60;
   localparam logic [5:0] F_MULTU = 6'd25;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  signal;
   logic        valid_in;
   logic        ready;
   logic [31:0] alu_in, shift_in, mul_a, mul_b;
   logic [31:0] result, hi_out, lo_out;
   logic        result_valid, busy, mul_done, state_dbg;

   logic [5:0]  s8;
   logic        v8, ready8, rv8, busy8, done8, dbg8;
   logic [7:0]  a8, b8, res8, hi8, lo8;

   int passes = 0;
   int checks = 0;
   int fails  = 0;

   // Reference model of the architectural HI/LO pair.
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   alu_result_unit dut (
      .clk(clk), .rst_n(rst_n), .signal(signal), .valid_in(valid_in), .ready(ready),
      .alu_in(alu_in), .shift_in(shift_in), .mul_a(mul_a), .mul_b(mul_b),
      .result(result), .result_valid(result_valid), .busy(busy), .mul_done(mul_done),
      .hi_out(hi_out), .lo_out(lo_out), .state_dbg(state_dbg)
   );

   alu_result_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .signal(s8), .valid_in(v8), .ready(ready8),
      .alu_in(8'h00), .shift_in(8'h00), .mul_a(a8), .mul_b(b8),
      .result(res8), .result_valid(rv8), .busy(busy8), .mul_done(done8),
      .hi_out(hi8), .lo_out(lo8), .state_dbg(dbg8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_sel(input logic [5:0] sig, input logic [31:0] a,
                                           input logic [31:0] s);
      if (sig == F_ALU)        return a;
      else if (sig == F_SHIFT) return s;
      else if (sig == F_HI)    return m_hi;
      else if (sig == F_LO)    return m_lo;
      else                     return 32'h0;
   endfunction

   task automatic issue(input string tag, input logic [5:0] sig, input logic [31:0] a,
                        input logic [31:0] s);
      logic [31:0] exp;
      exp      = exp_sel(sig, a, s);
      signal   = sig;
      alu_in   = a;
      shift_in = s;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check({tag, "_res"}, result, exp);
      check({tag, "_rv"}, result_valid, 1'b1);
   endtask

   // Runs one MULTU; optionally scrambles the operand inputs and/or holds an
   // F_ALU issue pending for the whole multiply.
   task automatic mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, input bit stall, input logic [31:0] stall_val);
      logic [63:0] prod;
      int busy_cyc, done_cnt, bad;
      prod     = {32'h0, a} * {32'h0, b};
      signal   = F_MULTU;
      mul_a    = a;
      mul_b    = b;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check({tag, "_busy0"}, busy, 1'b1);
      check({tag, "_done0"}, mul_done, 1'b0);
      if (stall) begin
         signal   = F_ALU;
         alu_in   = stall_val;
         valid_in = 1'b1;
      end
      busy_cyc = 1;
      done_cnt = 0;
      bad      = 0;
      for (int k = 0; k < 100; k++) begin
         if (scramble) begin
            mul_a = $urandom;
            mul_b = $urandom;
         end
         tick();
         if (mul_done) done_cnt++;
         if (!busy) break;
         busy_cyc++;
         if (hi_out !== m_hi || lo_out !== m_lo || result_valid !== 1'b0 || ready !== 1'b0)
            bad++;
      end
      check({tag, "_busy_cycles"}, busy_cyc, 32);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_hidden"}, bad, 0);
      check({tag, "_hi"}, hi_out, prod[63:32]);
      check({tag, "_lo"}, lo_out, prod[31:0]);
      check({tag, "_ready"}, ready, 1'b1);
      m_hi = prod[63:32];
      m_lo = prod[31:0];
      if (stall) begin
         tick();
         valid_in = 1'b0;
         check({tag, "_stall_res"}, result, stall_val);
         check({tag, "_stall_rv"}, result_valid, 1'b1);
         tick();
         check({tag, "_stall_once"}, result_valid, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra, rb, rv;
      logic [5:0]  code;
      logic [15:0] p8;
      int cnt, dcnt, seen;

      // Reset with a pending issue that must be ignored.
      rst_n = 1'b0; valid_in = 1'b1; signal = F_ALU; alu_in = 32'hDEADBEEF;
      shift_in = '0; mul_a = '0; mul_b = '0;
      s8 = F_MULTU; v8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
      m_hi = '0; m_lo = '0;
      tick();
      tick();
      check("rst_result", result, 32'h0);
      check("rst_rv", result_valid, 1'b0);
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst8_busy", busy8, 1'b0);
      rst_n = 1'b1; valid_in = 1'b0; v8 = 1'b0;
      tick();
      check("idle_rv", result_valid, 1'b0);

      // Back-to-back select path.
      signal = F_ALU; alu_in = 32'h12345678; valid_in = 1'b1;
      tick();
      check("sel_alu", result, 32'h12345678);
      check("sel_alu_rv", result_valid, 1'b1);
      signal = F_SHIFT; shift_in = 32'hA5A5A5A5;
      tick();
      check("sel_shift", result, 32'hA5A5A5A5);
      check("sel_shift_rv", result_valid, 1'b1);
      signal = 6'd7;
      tick();
      valid_in = 1'b0;
      check("sel_other", result, 32'h0);
      check("sel_other_rv", result_valid, 1'b1);
      tick();
      check("sel_pulse_end", result_valid, 1'b0);
      check("sel_hold", result, 32'h0);

      mult("small", 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
      issue("small_lo", F_LO, 32'h1111, 32'h2222);
      issue("small_hi", F_HI, 32'h1111, 32'h2222);
      check("small_lo_val", m_lo, 32'h0000000F);

      mult("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
      check("max_hi_const", hi_out, 32'hFFFFFFFE);
      check("max_lo_const", lo_out, 32'h00000001);
      issue("max_hi_rd", F_HI, 32'h0, 32'h0);

      mult("stall", $urandom, $urandom, 1'b1, 1'b1, $urandom);

      // Randomized multiplies, immediately back-to-back, each followed by a random read.
      for (int i = 0; i < 6; i++) begin
         mult("rnd_a", $urandom, $urandom, 1'b1, 1'b0, 32'h0);
         mult("rnd_b", $urandom, $urandom, 1'b0, 1'b0, 32'h0);
         case ($urandom_range(0, 4))
            0: code = F_ALU;
            1: code = F_SHIFT;
            2: code = F_HI;
            3: code = F_LO;
            default: code = 6'($urandom_range(26, 59));
         endcase
         ra = $urandom; rb = $urandom;
         issue("rnd_sel", code, ra, rb);
      end

      // Reset in the middle of a multiply.
      mult("pre", 32'd2, 32'h80000001, 1'b0, 1'b0, 32'h0);
      check("pre_hi", hi_out, 32'h1);
      check("pre_lo", lo_out, 32'h2);
      signal = F_MULTU; mul_a = $urandom; mul_b = $urandom; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      check("mrst_busy", busy, 1'b0);
      check("mrst_hi", hi_out, 32'h0);
      check("mrst_lo", lo_out, 32'h0);
      check("mrst_done", mul_done, 1'b0);
      check("mrst_ready", ready, 1'b1);
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (mul_done) seen++;
      end
      check("mrst_no_done", seen, 0);
      issue("mrst_lo_rd", F_LO, 32'h0, 32'h0);

      // WIDTH=8 regression instance.
      for (int i = 0; i < 3; i++) begin
         a8 = (i == 0) ? 8'hFF : 8'($urandom);
         b8 = (i == 0) ? 8'hFF : 8'($urandom);
         p8 = {8'h0, a8} * {8'h0, b8};
         s8 = F_MULTU; v8 = 1'b1;
         tick();
         v8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         cnt = 1; dcnt = 0;
         for (int k = 0; k < 50; k++) begin
            tick();
            if (done8) dcnt++;
            if (!busy8) break;
            cnt++;
         end
         check("w8_busy_cycles", cnt, 8);
         check("w8_done", dcnt, 1);
         check("w8_hi", hi8, p8[15:8]);
         check("w8_lo", lo8, p8[7:0]);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
